d0fifo_ctrl: RTL and testbench
==============================

# d0fifo_ctrl

Synchronous FIFO controller that initiates all traffic into an external zero-read-latency RAM: it owns the write/read pointers and occupancy, converts valid/ready streams into RAM write and read strobes, and returns RAM read data to the consumer in the same cycle. It sits between a producer stream and a consumer stream, with the storage array instantiated alongside it by the parent.

## Interface
- WIDTH, 16, data word width
- DEPTH, 32, entries; power of two, ≥ 2
- AF_LEVEL, DEPTH-2, occupancy at or above which almost_full asserts; range 1..DEPTH
- AW = $clog2(DEPTH), derived localparam

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of pointers and count
- in_valid  in  1  producer has a word
- in_ready  out  1  controller accepts the word
- in_data  in  WIDTH  producer word
- out_valid  out  1  head word available
- out_ready  in  1  consumer takes the head word
- out_data  out  WIDTH  head word
- count  out  AW+1  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- ram_wen  out  1  RAM write strobe
- ram_waddr  out  AW  RAM write address
- ram_wdata  out  WIDTH  RAM write data
- ram_ren  out  1  RAM read enable
- ram_raddr  out  AW  RAM read address
- ram_rdata  in  WIDTH  RAM read data; valid in the same cycle as ram_ren/ram_raddr

## Operation
- State: wptr, rptr, each AW+1 bits (AW address bits plus wrap bit); count register, AW+1 bits.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = !full; a push is refused when full, even if a pop occurs in the same cycle.
- out_valid = !empty; a word written this cycle is not poppable until the next cycle.
- ram_wen = push; ram_waddr = wptr[AW-1:0]; ram_wdata = in_data (combinational pass-through).
- ram_ren = out_valid; ram_raddr = rptr[AW-1:0]; out_data = ram_rdata when out_valid, else 0.
- On push: wptr += 1 (wraps modulo 2·DEPTH). On pop: rptr += 1.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- full = (wptr[AW] != rptr[AW]) & (wptr[AW-1:0] == rptr[AW-1:0]); empty = (wptr == rptr). Both must agree with count at all times.
- flush: next cycle wptr = rptr = 0 and count = 0; any push or pop in the flush cycle is discarded. ram_wen remains combinational, so a same-cycle write still reaches the RAM, but the written word is unreachable. RAM contents are not cleared.
- The consumer must hold out_ready stable only for the cycle it is sampled; no other consumer protocol is imposed.

## Timing
- Reset values: wptr = rptr = 0, count = 0, empty = 1, full = 0, almost_full = 0 (AF_LEVEL ≥ 1), in_ready = 1, out_valid = 0, out_data = 0, ram_wen = 0 (in_valid low), ram_ren = 0.
- Write-to-read latency: word pushed at edge N is presented on out_data with out_valid high in cycle N+1. This covers the first word into an empty FIFO.
- Pop latency 0: out_data is valid in the same cycle out_valid is high. The next word appears the cycle after a pop.
- Full: 0 → DEPTH pushes without pops sets full after the DEPTH-th edge. in_ready drops in the same cycle.
- Simultaneous push and pop, not full and not empty: count unchanged, both pointers advance.
- Pointer wrap: after 2·DEPTH pushes wptr returns to 0 with no glitch on full/empty.
- Asynchronous reset mid-transfer: all state clears immediately. A push in flight is lost.

## Structure
- Shared package: the pointer type (logic [AW:0]) and a pointer increment function. No other package content.
- One natural sub-module, fifo_ptr: AW+1-bit pointer register with increment enable and synchronous clear, instantiated twice, once for the write pointer and once for the read pointer.
- count, flags and handshakes live in the top level. The RAM is instantiated by the parent, not inside this block.

## Test plan
- Reset with DEPTH=4: all outputs match their reset values; drive in_valid=1, in_data=0xA5A5 for one cycle → out_valid=1 and out_data=0xA5A5 on the next cycle, count=1.
- Fill DEPTH=4 with 1,2,3,4 → full=1, in_ready=0, and a fifth push of 5 is ignored; drain → outputs 1,2,3,4 in order, then empty=1.
- At count=2, push and pop every cycle for 20 cycles → count stays at 2, data order is preserved, and pointers wrap past 2·DEPTH.
- Full, with in_valid=1 and out_ready=1 in the same cycle → pop only, count=3, the refused word is not written (ram_wen=0).
- At count=3, assert flush with in_valid=1 → next cycle count=0, empty=1, out_valid=0; a subsequent push of 0x1234 reads back 0x1234.
- AF_LEVEL=3, DEPTH=4: almost_full rises on the 3rd push and falls on the pop that brings count back to 2; assert rst_n low mid-burst → state clears immediately.

Source files
------------

// File: rtl/d0fifo_ctrl_pkg.sv
// Shared pointer type and increment helper for the d0fifo controller.
// ptr_t is sized for the largest supported depth; pointer registers keep only their low AW+1 bits.
package d0fifo_ctrl_pkg;

    localparam int PTR_MAX_AW = 30;

    typedef logic [PTR_MAX_AW:0] ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/d0fifo_ctrl_if.sv
// Producer and consumer valid/ready streams for the d0fifo controller.
// The controller uses the slave modport and the environment uses the master modport.
interface d0fifo_ctrl_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/d0fifo_ctrl_fifo_ptr.sv
// AW+1-bit FIFO pointer (address bits plus wrap bit) with increment enable and synchronous clear.
// The pointer wraps modulo 2*DEPTH because only the low AW+1 bits of the increment are kept.
module fifo_ptr
    import d0fifo_ctrl_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [AW:0]   o_ptr
);

    logic [AW:0] r_ptr;
    ptr_t        w_next;
    logic        w_unused_hi;

    assign w_next      = ptr_inc({{(PTR_MAX_AW - AW){1'b0}}, r_ptr});
    assign w_unused_hi = ^w_next[PTR_MAX_AW:AW+1];
    assign o_ptr       = r_ptr;

    // Clear takes priority so a flush discards any same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= w_next[AW:0];
        end
    end

endmodule

// File: rtl/d0fifo_ctrl.sv
// FIFO controller driving an external zero-read-latency RAM owned by the parent.
// It holds the pointers and occupancy and maps the valid/ready streams onto RAM strobes.
module d0fifo_ctrl
    import d0fifo_ctrl_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int DEPTH    = 32,
    parameter  int AF_LEVEL = DEPTH - 2,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    d0fifo_ctrl_if.slave      s_if,
    output logic [AW:0]       o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_almost_full,
    output logic              o_ram_wen,
    output logic [AW-1:0]     o_ram_waddr,
    output logic [WIDTH-1:0]  o_ram_wdata,
    output logic              o_ram_ren,
    output logic [AW-1:0]     o_ram_raddr,
    input  logic [WIDTH-1:0]  i_ram_rdata
);

    logic [AW:0] w_wptr;
    logic [AW:0] w_rptr;
    logic [AW:0] r_count;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;

    fifo_ptr #(.AW(AW)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (i_flush),
        .i_inc (w_push),
        .o_ptr (w_wptr)
    );

    fifo_ptr #(.AW(AW)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (i_flush),
        .i_inc (w_pop),
        .o_ptr (w_rptr)
    );

    // Same address with differing wrap bits means the writer is a full lap ahead.
    assign w_full  = (w_wptr[AW] != w_rptr[AW]) && (w_wptr[AW-1:0] == w_rptr[AW-1:0]);
    assign w_empty = (w_wptr == w_rptr);

    assign w_push = s_if.in_valid && !w_full;
    assign w_pop  = !w_empty && s_if.out_ready;

    assign s_if.in_ready  = !w_full;
    assign s_if.out_valid = !w_empty;
    assign s_if.out_data  = w_empty ? '0 : i_ram_rdata;

    assign o_ram_wen   = w_push;
    assign o_ram_waddr = w_wptr[AW-1:0];
    assign o_ram_wdata = s_if.in_data;
    assign o_ram_ren   = !w_empty;
    assign o_ram_raddr = w_rptr[AW-1:0];

    assign o_count       = r_count;
    assign o_full        = w_full;
    assign o_empty       = w_empty;
    assign o_almost_full = (r_count >= (AW+1)'(AF_LEVEL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: tb/tb_d0fifo_ctrl.sv
// Randomized and directed bench for d0fifo_ctrl with DEPTH=4, AF_LEVEL=3.
// A queue-based reference model predicts every output; the bench also plays the role of the RAM.
module tb_d0fifo_ctrl;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 4;
    localparam int AF_LEVEL = 3;
    localparam int AW       = $clog2(DEPTH);

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             almostFull;
    logic             ramWen;
    logic [AW-1:0]    ramWaddr;
    logic [WIDTH-1:0] ramWdata;
    logic             ramRen;
    logic [AW-1:0]    ramRaddr;
    logic [WIDTH-1:0] ramRdata;
    logic [WIDTH-1:0] mem [DEPTH];

    int totalChecks;
    int badChecks;
    int modelQ[$];
    int modelWaddr;
    int modelRaddr;

    d0fifo_ctrl_if #(.WIDTH(WIDTH)) ifc ();

    d0fifo_ctrl #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_flush       (flush),
        .s_if          (ifc),
        .o_count       (count),
        .o_full        (full),
        .o_empty       (empty),
        .o_almost_full (almostFull),
        .o_ram_wen     (ramWen),
        .o_ram_waddr   (ramWaddr),
        .o_ram_wdata   (ramWdata),
        .o_ram_ren     (ramRen),
        .o_ram_raddr   (ramRaddr),
        .i_ram_rdata   (ramRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-latency RAM owned by the parent.
    always @(posedge clk) begin
        if (ramWen) mem[ramWaddr] <= ramWdata;
    end
    assign ramRdata = mem[ramRaddr];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalChecks++;
        if (obs !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAll();
        int n;
        n = modelQ.size();
        checkOutput("in_ready",    ifc.in_ready,  n < DEPTH);
        checkOutput("out_valid",   ifc.out_valid, n > 0);
        checkOutput("out_data",    ifc.out_data,  (n > 0) ? modelQ[0] : 0);
        checkOutput("count",       count,         n);
        checkOutput("full",        full,          n == DEPTH);
        checkOutput("empty",       empty,         n == 0);
        checkOutput("almost_full", almostFull,    n >= AF_LEVEL);
        checkOutput("ram_wen",     ramWen,        ifc.in_valid && (n < DEPTH));
        checkOutput("ram_waddr",   ramWaddr,      modelWaddr);
        checkOutput("ram_wdata",   ramWdata,      ifc.in_data);
        checkOutput("ram_ren",     ramRen,        n > 0);
        checkOutput("ram_raddr",   ramRaddr,      modelRaddr);
    endtask

    task automatic clearModel();
        modelQ.delete();
        modelWaddr = 0;
        modelRaddr = 0;
    endtask

    // One clock cycle: drive inputs, check mid-cycle, then advance the model at the edge.
    task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] data,
                                 input logic ready, input logic fl);
        bit doPush;
        bit doPop;
        ifc.in_valid  = valid;
        ifc.in_data   = data;
        ifc.out_ready = ready;
        flush         = fl;
        @(negedge clk);
        checkAll();
        doPush = valid && (modelQ.size() < DEPTH);
        doPop  = ready && (modelQ.size() > 0);
        @(posedge clk);
        if (fl) begin
            clearModel();
        end else begin
            if (doPop) begin
                void'(modelQ.pop_front());
                modelRaddr = (modelRaddr + 1) % DEPTH;
            end
            if (doPush) begin
                modelQ.push_back(int'(data));
                modelWaddr = (modelWaddr + 1) % DEPTH;
            end
        end
        #1;
    endtask

    initial begin
        totalChecks = 0;
        badChecks   = 0;
        clearModel();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.out_ready = 1'b0;

        @(negedge clk);
        checkAll();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First word into an empty FIFO is visible the next cycle.
        applyStimulus(1'b1, 16'hA5A5, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        // Fill, refused fifth push, drain.
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        // Steady push+pop at count=2 so the pointers wrap several times.
        applyStimulus(1'b1, 16'h0101, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0202, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 16'(16'h1000 + i), 1'b1, 1'b0);

        // Fill to full, then a same-cycle push and pop: only the pop happens.
        applyStimulus(1'b1, 16'h0303, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0404, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hDEAD, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

        // Flush at count=3 with a push in flight, then a fresh word.
        applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

        // almost_full rises on the third push and falls when a pop returns count to 2.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'(16'h2000 + i), 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a burst clears state immediately.
        applyStimulus(1'b1, 16'h3000, 1'b0, 1'b0);
        ifc.in_valid = 1'b1;
        ifc.in_data  = 16'h3001;
        #2;
        rst_n = 1'b0;
        clearModel();
        #1;
        checkAll();
        ifc.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) < 60,
                          16'($urandom),
                          $urandom_range(0, 99) < 50,
                          $urandom_range(0, 99) < 3);
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
